// File: rtl/f_sub16_serial.sv
// Bit-serial subtractor: computes ain - bin - bwin one bit per clock, LSB
// first, and reports the difference, the borrow-out and the two's-complement
// overflow.
// A run takes WIDTH cycles in SHIFT, followed by one DONE cycle.
module f_sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             bwin,
  output logic [WIDTH-1:0] dout,
  output logic             bwout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bw;
  logic [WIDTH-1:0] r_dout;
  logic             r_bwout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_bit;
  logic             w_d;
  logic             w_bw_nxt;
  logic [WIDTH-1:0] w_res_nxt;

  // One-bit full subtractor: returns {borrow_out, difference}.
  function automatic logic [1:0] fsub_bit(input logic a, input logic b, input logic bw);
    logic d;
    logic bo;
    d  = a ^ b ^ bw;
    bo = (~a & b) | (~(a ^ b) & bw);
    return {bo, d};
  endfunction

  // A new run may start from IDLE or directly from DONE (back-to-back).
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_bit     = fsub_bit(r_a[0], r_b[0], r_bw);
  assign w_d       = w_bit[0];
  assign w_bw_nxt  = w_bit[1];
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start during SHIFT is deliberately not looked at.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SHIFT;
        else       w_state_nxt = ST_IDLE;
      end
      ST_SHIFT: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_SHIFT;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_SHIFT;
        else       w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand/result shift registers, running borrow and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= {WIDTH{1'b0}};
      r_b   <= {WIDTH{1'b0}};
      r_res <= {WIDTH{1'b0}};
      r_bw  <= 1'b0;
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_a   <= ain;
      r_b   <= bin;
      r_res <= {WIDTH{1'b0}};
      r_bw  <= bwin;
      r_cnt <= {CW{1'b0}};
    end else if (r_state == ST_SHIFT) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res_nxt;
      r_bw  <= w_bw_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers: updated only on the final bit, held otherwise.
  // On the last bit r_a[0]/r_b[0] are the original operand MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= {WIDTH{1'b0}};
      r_bwout <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_last) begin
      r_dout  <= w_res_nxt;
      r_bwout <= w_bw_nxt;
      r_ovf   <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
    end
  end

  // Status flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_SHIFT);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign dout  = r_dout;
  assign bwout = r_bwout;
  assign ovf   = r_ovf;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
